// File: rtl/riscv_pkg.sv
// RV32I decode definitions shared by the decode stage and its bench.
//   - opcode constants for the supported instruction classes
//   - alu_op_e   : 4-bit ALU operation carried in alu_ctrl_id
//   - wb_sel_e   : writeback source select carried in wb_sel_id
//   - imm_type_e : immediate format chosen by the decoder
//   - imm_gen    : sign-extending immediate builder
//   - alu_from_f3: funct3 (+ alternate bit) to ALU operation
package riscv_pkg;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  typedef enum logic [3:0] {
    ALU_ADD    = 4'd0,
    ALU_SUB    = 4'd1,
    ALU_SLL    = 4'd2,
    ALU_SLT    = 4'd3,
    ALU_SLTU   = 4'd4,
    ALU_XOR    = 4'd5,
    ALU_SRL    = 4'd6,
    ALU_SRA    = 4'd7,
    ALU_OR     = 4'd8,
    ALU_AND    = 4'd9,
    ALU_PASS_B = 4'd10
  } alu_op_e;

  typedef enum logic [1:0] {
    WB_ALU = 2'd0,
    WB_MEM = 2'd1,
    WB_PC4 = 2'd2
  } wb_sel_e;

  typedef enum logic [2:0] {
    IMM_NONE,
    IMM_I,
    IMM_S,
    IMM_B,
    IMM_U,
    IMM_J
  } imm_type_e;

  function automatic logic [31:0] imm_gen(input logic [31:0] instr, input imm_type_e t);
    logic [31:0] imm;
    imm = '0;
    case (t)
      IMM_I:   imm = {{20{instr[31]}}, instr[31:20]};
      IMM_S:   imm = {{20{instr[31]}}, instr[31:25], instr[11:7]};
      IMM_B:   imm = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
      IMM_U:   imm = {instr[31:12], 12'b0};
      IMM_J:   imm = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
      default: imm = '0;
    endcase
    return imm;
  endfunction

  // alt selects SUB over ADD and SRA over SRL
  function automatic alu_op_e alu_from_f3(input logic [2:0] f3, input logic alt);
    alu_op_e op;
    case (f3)
      3'b000:  op = alt ? ALU_SUB : ALU_ADD;
      3'b001:  op = ALU_SLL;
      3'b010:  op = ALU_SLT;
      3'b011:  op = ALU_SLTU;
      3'b100:  op = ALU_XOR;
      3'b101:  op = alt ? ALU_SRA : ALU_SRL;
      3'b110:  op = ALU_OR;
      default: op = ALU_AND;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/decode_stage_if.sv
// IF/ID -> decode -> ID/EX bus.
//   master: fetch side / downstream consumer (drives IF/ID, observes ID/EX)
//   slave : decode_stage (consumes IF/ID, drives rs*_addr_dec and ID/EX)
interface decode_stage_if #(
  parameter int unsigned XLEN = 32
);
  logic [31:0]     instr_if;
  logic [XLEN-1:0] pc_if;
  logic [XLEN-1:0] pc4_if;

  logic [4:0]      rs1_addr_dec;
  logic [4:0]      rs2_addr_dec;

  logic [XLEN-1:0] rs1_data_id;
  logic [XLEN-1:0] rs2_data_id;
  logic [XLEN-1:0] imm_id;
  logic [4:0]      rs1_addr_id;
  logic [4:0]      rs2_addr_id;
  logic [4:0]      rd_addr_id;
  logic [XLEN-1:0] pc_id;
  logic [XLEN-1:0] pc4_id;
  logic [2:0]      funct3_id;
  logic [3:0]      alu_ctrl_id;
  logic            alu_src_a_id;
  logic            alu_src_b_id;
  logic [1:0]      wb_sel_id;
  logic            reg_we_id;
  logic            mem_re_id;
  logic            mem_we_id;
  logic            branch_id;
  logic            jal_id;
  logic            jalr_id;
  logic            illegal_id;

  modport master (
    output instr_if, pc_if, pc4_if,
    input  rs1_addr_dec, rs2_addr_dec,
    input  rs1_data_id, rs2_data_id, imm_id, rs1_addr_id, rs2_addr_id, rd_addr_id,
    input  pc_id, pc4_id, funct3_id, alu_ctrl_id, alu_src_a_id, alu_src_b_id,
    input  wb_sel_id, reg_we_id, mem_re_id, mem_we_id, branch_id, jal_id, jalr_id,
    input  illegal_id
  );

  modport slave (
    input  instr_if, pc_if, pc4_if,
    output rs1_addr_dec, rs2_addr_dec,
    output rs1_data_id, rs2_data_id, imm_id, rs1_addr_id, rs2_addr_id, rd_addr_id,
    output pc_id, pc4_id, funct3_id, alu_ctrl_id, alu_src_a_id, alu_src_b_id,
    output wb_sel_id, reg_we_id, mem_re_id, mem_we_id, branch_id, jal_id, jalr_id,
    output illegal_id
  );
endinterface

// File: rtl/regfile.sv
// Architectural register file, 2 combinational read ports, 1 write port.
//   clk, reset        : clock, asynchronous active-high reset (clears x1..xN-1)
//   we, waddr, wdata  : writeback port; writes to x0 are dropped
//   raddr1/2, rdata1/2: read ports; x0 reads 0, same-cycle write is bypassed
module regfile #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned NREGS = 32,
  parameter int unsigned AW    = $clog2(NREGS)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            we,
  input  logic [AW-1:0]   waddr,
  input  logic [XLEN-1:0] wdata,
  input  logic [AW-1:0]   raddr1,
  output logic [XLEN-1:0] rdata1,
  input  logic [AW-1:0]   raddr2,
  output logic [XLEN-1:0] rdata2
);

  logic [XLEN-1:0] regs [1:NREGS-1];
  logic            wr_en;

  assign wr_en = we && (waddr != '0);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int unsigned i = 1; i < NREGS; i++) regs[i] <= '0;
    end else if (wr_en) begin
      regs[waddr] <= wdata;
    end
  end

  assign rdata1 = (raddr1 == '0)               ? '0    :
                  (wr_en && waddr == raddr1)   ? wdata : regs[raddr1];
  assign rdata2 = (raddr2 == '0)               ? '0    :
                  (wr_en && waddr == raddr2)   ? wdata : regs[raddr2];

endmodule

// File: rtl/decode_stage.sv
// RV32I instruction-decode stage with ID/EX pipeline register.
//   clk, reset               : clock, asynchronous active-high reset
//   wb_we, wb_rd, wb_data    : register-file write port from writeback
//   stall_id, flush_id       : hazard control of ID/EX (flush wins over stall)
//   bus (decode_stage_if)    : IF/ID inputs, rs*_addr_dec to hazard unit,
//                              registered ID/EX outputs
module decode_stage
  import riscv_pkg::*;
#(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned NREGS = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            wb_we,
  input  logic [4:0]      wb_rd,
  input  logic [XLEN-1:0] wb_data,
  input  logic            stall_id,
  input  logic            flush_id,
  decode_stage_if.slave   bus
);

  typedef struct packed {
    logic [XLEN-1:0] rs1_data;
    logic [XLEN-1:0] rs2_data;
    logic [XLEN-1:0] imm;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] pc4;
    logic [4:0]      rs1_addr;
    logic [4:0]      rs2_addr;
    logic [4:0]      rd_addr;
    logic [2:0]      funct3;
    alu_op_e         alu_ctrl;
    logic            alu_src_a;
    logic            alu_src_b;
    wb_sel_e         wb_sel;
    logic            reg_we;
    logic            mem_re;
    logic            mem_we;
    logic            branch;
    logic            jal;
    logic            jalr;
    logic            illegal;
  } id_ex_t;

  logic [31:0]     instr;
  logic [XLEN-1:0] rs1_rdata, rs2_rdata;
  id_ex_t          dec, idex;
  imm_type_e       imm_t;

  assign instr            = bus.instr_if;
  assign bus.rs1_addr_dec = instr[19:15];
  assign bus.rs2_addr_dec = instr[24:20];

  regfile #(
    .XLEN  (XLEN),
    .NREGS (NREGS)
  ) u_regfile (
    .clk    (clk),
    .reset  (reset),
    .we     (wb_we),
    .waddr  (wb_rd),
    .wdata  (wb_data),
    .raddr1 (instr[19:15]),
    .rdata1 (rs1_rdata),
    .raddr2 (instr[24:20]),
    .rdata2 (rs2_rdata)
  );

  always_comb begin
    dec          = '0;
    imm_t        = IMM_NONE;
    dec.rs1_addr = instr[19:15];
    dec.rs2_addr = instr[24:20];
    dec.rs1_data = rs1_rdata;
    dec.rs2_data = rs2_rdata;
    dec.pc       = bus.pc_if;
    dec.pc4      = bus.pc4_if;
    dec.funct3   = instr[14:12];
    case (instr[6:0])
      OP_R: begin
        // only funct7 0000000, or 0100000 on SUB/SRA, is a valid R-type
        if (instr[31:25] == 7'b0000000 ||
            (instr[31:25] == 7'b0100000 && (instr[14:12] == 3'b000 || instr[14:12] == 3'b101))) begin
          dec.reg_we   = 1'b1;
          dec.alu_ctrl = alu_from_f3(instr[14:12], instr[30]);
        end else begin
          dec.illegal  = 1'b1;
        end
      end
      OP_IMM: begin
        imm_t         = IMM_I;
        dec.reg_we    = 1'b1;
        dec.alu_src_b = 1'b1;
        // bit 30 is immediate data except on SRAI
        dec.alu_ctrl  = alu_from_f3(instr[14:12], instr[14:12] == 3'b101 && instr[30]);
      end
      OP_LOAD: begin
        imm_t         = IMM_I;
        dec.reg_we    = 1'b1;
        dec.mem_re    = 1'b1;
        dec.alu_src_b = 1'b1;
        dec.wb_sel    = WB_MEM;
      end
      OP_STORE: begin
        imm_t         = IMM_S;
        dec.mem_we    = 1'b1;
        dec.alu_src_b = 1'b1;
      end
      OP_BRANCH: begin
        imm_t         = IMM_B;
        dec.branch    = 1'b1;
        dec.alu_ctrl  = ALU_SUB;
      end
      OP_JAL: begin
        imm_t         = IMM_J;
        dec.jal       = 1'b1;
        dec.reg_we    = 1'b1;
        dec.alu_src_a = 1'b1;
        dec.alu_src_b = 1'b1;
        dec.wb_sel    = WB_PC4;
      end
      OP_JALR: begin
        imm_t         = IMM_I;
        dec.jalr      = 1'b1;
        dec.reg_we    = 1'b1;
        dec.alu_src_b = 1'b1;
        dec.wb_sel    = WB_PC4;
      end
      OP_LUI: begin
        imm_t         = IMM_U;
        dec.reg_we    = 1'b1;
        dec.alu_src_b = 1'b1;
        dec.alu_ctrl  = ALU_PASS_B;
      end
      OP_AUIPC: begin
        imm_t         = IMM_U;
        dec.reg_we    = 1'b1;
        dec.alu_src_a = 1'b1;
        dec.alu_src_b = 1'b1;
      end
      // an all-zero word is a fetch bubble, not an illegal instruction
      default: dec.illegal = (instr != '0);
    endcase
    dec.imm     = imm_gen(instr, imm_t);
    dec.rd_addr = dec.reg_we ? instr[11:7] : '0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)          idex <= '0;
    else if (flush_id)  idex <= '0;
    else if (!stall_id) idex <= dec;
  end

  assign bus.rs1_data_id  = idex.rs1_data;
  assign bus.rs2_data_id  = idex.rs2_data;
  assign bus.imm_id       = idex.imm;
  assign bus.rs1_addr_id  = idex.rs1_addr;
  assign bus.rs2_addr_id  = idex.rs2_addr;
  assign bus.rd_addr_id   = idex.rd_addr;
  assign bus.pc_id        = idex.pc;
  assign bus.pc4_id       = idex.pc4;
  assign bus.funct3_id    = idex.funct3;
  assign bus.alu_ctrl_id  = idex.alu_ctrl;
  assign bus.alu_src_a_id = idex.alu_src_a;
  assign bus.alu_src_b_id = idex.alu_src_b;
  assign bus.wb_sel_id    = idex.wb_sel;
  assign bus.reg_we_id    = idex.reg_we;
  assign bus.mem_re_id    = idex.mem_re;
  assign bus.mem_we_id    = idex.mem_we;
  assign bus.branch_id    = idex.branch;
  assign bus.jal_id       = idex.jal;
  assign bus.jalr_id      = idex.jalr;
  assign bus.illegal_id   = idex.illegal;

endmodule

// File: tb/tb_decode_stage.sv
// Scoreboard bench for decode_stage: each driven instruction pushes its
// expected ID/EX record, which is popped and compared after the clock edge.
module tb_decode_stage;
  import riscv_pkg::*;

  typedef struct {
    logic [31:0] rs1d, rs2d, imm, pc, pc4;
    logic [4:0]  rs1a, rs2a, rd;
    logic [2:0]  f3;
    logic [3:0]  alu;
    logic        src_a, src_b;
    logic [1:0]  wb;
    logic        reg_we, mem_re, mem_we, br, jal, jalr, ill;
    bit          chk_imm, chk_a;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        wb_we = 1'b0;
  logic [4:0]  wb_rd = '0;
  logic [31:0] wb_data = '0;
  logic        stall_id = 1'b0;
  logic        flush_id = 1'b0;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;
  exp_t        exp_q [$];

  decode_stage_if #(.XLEN(32)) bus ();

  decode_stage #(
    .XLEN  (32),
    .NREGS (32)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .wb_we    (wb_we),
    .wb_rd    (wb_rd),
    .wb_data  (wb_data),
    .stall_id (stall_id),
    .flush_id (flush_id),
    .bus      (bus)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  // zeroed expectation; register-address fields come straight from the word
  function automatic exp_t mk(input logic [31:0] instr, input logic [31:0] pc, input logic [31:0] pc4);
    exp_t e;
    e = '{default: '0};
    e.rs1a = instr[19:15];
    e.rs2a = instr[24:20];
    e.f3   = instr[14:12];
    e.pc   = pc;
    e.pc4  = pc4;
    e.chk_imm = 1'b1;
    e.chk_a   = 1'b1;
    return e;
  endfunction

  task automatic compare_out(input string tag);
    exp_t e;
    if (exp_q.size() == 0) begin
      check_eq({tag, ".queue"}, 32'd0, 32'd1);
      return;
    end
    e = exp_q.pop_front();
    check_eq({tag, ".rs1_data"}, bus.rs1_data_id, e.rs1d);
    check_eq({tag, ".rs2_data"}, bus.rs2_data_id, e.rs2d);
    if (e.chk_imm) check_eq({tag, ".imm"}, bus.imm_id, e.imm);
    check_eq({tag, ".rs1_addr"}, 32'(bus.rs1_addr_id), 32'(e.rs1a));
    check_eq({tag, ".rs2_addr"}, 32'(bus.rs2_addr_id), 32'(e.rs2a));
    check_eq({tag, ".rd_addr"},  32'(bus.rd_addr_id),  32'(e.rd));
    check_eq({tag, ".pc"},       bus.pc_id,  e.pc);
    check_eq({tag, ".pc4"},      bus.pc4_id, e.pc4);
    check_eq({tag, ".funct3"},   32'(bus.funct3_id),   32'(e.f3));
    check_eq({tag, ".alu_ctrl"}, 32'(bus.alu_ctrl_id), 32'(e.alu));
    if (e.chk_a) check_eq({tag, ".alu_src_a"}, 32'(bus.alu_src_a_id), 32'(e.src_a));
    check_eq({tag, ".alu_src_b"}, 32'(bus.alu_src_b_id), 32'(e.src_b));
    check_eq({tag, ".wb_sel"},  32'(bus.wb_sel_id),  32'(e.wb));
    check_eq({tag, ".reg_we"},  32'(bus.reg_we_id),  32'(e.reg_we));
    check_eq({tag, ".mem_re"},  32'(bus.mem_re_id),  32'(e.mem_re));
    check_eq({tag, ".mem_we"},  32'(bus.mem_we_id),  32'(e.mem_we));
    check_eq({tag, ".branch"},  32'(bus.branch_id),  32'(e.br));
    check_eq({tag, ".jal"},     32'(bus.jal_id),     32'(e.jal));
    check_eq({tag, ".jalr"},    32'(bus.jalr_id),    32'(e.jalr));
    check_eq({tag, ".illegal"}, 32'(bus.illegal_id), 32'(e.ill));
  endtask

  task automatic step(input string tag, input logic [31:0] instr, input logic [31:0] pc,
                      input logic [31:0] pc4, input exp_t e);
    bus.instr_if = instr;
    bus.pc_if    = pc;
    bus.pc4_if   = pc4;
    exp_q.push_back(e);
    #1;
    check_eq({tag, ".rs1_addr_dec"}, 32'(bus.rs1_addr_dec), 32'(instr[19:15]));
    check_eq({tag, ".rs2_addr_dec"}, 32'(bus.rs2_addr_dec), 32'(instr[24:20]));
    @(posedge clk);
    #1;
    compare_out(tag);
  endtask

  initial begin
    exp_t e, held;

    bus.instr_if = 32'hFFFF_FFFF;
    bus.pc_if    = 32'h0000_0400;
    bus.pc4_if   = 32'h0000_0404;
    repeat (2) @(posedge clk);
    #1;
    exp_q.push_back(mk(32'h0, 32'h0, 32'h0));
    compare_out("reset");
    reset = 1'b0;

    for (int i = 0; i < 3; i++) step("bubble", 32'h0, 32'h0, 32'h0, mk(32'h0, 32'h0, 32'h0));

    wb_we = 1'b1; wb_rd = 5'd5; wb_data = 32'h1234_5678;
    step("wr_x5", 32'h0, 32'h0, 32'h0, mk(32'h0, 32'h0, 32'h0));
    wb_we = 1'b0;

    e = mk(32'h0002_8313, 32'h100, 32'h104);
    e.rs1d = 32'h1234_5678; e.rd = 5'd6; e.reg_we = 1'b1; e.alu = ALU_ADD; e.src_b = 1'b1;
    step("addi", 32'h0002_8313, 32'h100, 32'h104, e);

    wb_we = 1'b1; wb_rd = 5'd1; wb_data = 32'hDEAD_BEEF;
    e = mk(32'h0000_8033, 32'h104, 32'h108);
    e.rs1d = 32'hDEAD_BEEF; e.reg_we = 1'b1; e.alu = ALU_ADD; e.chk_imm = 1'b0;
    step("bypass", 32'h0000_8033, 32'h104, 32'h108, e);

    wb_we = 1'b1; wb_rd = 5'd0; wb_data = 32'hFFFF_FFFF;
    step("x0_wr", 32'h0000_8033, 32'h104, 32'h108, e);
    wb_we = 1'b0;

    e = mk(32'h0000_0393, 32'h108, 32'h10C);
    e.rd = 5'd7; e.reg_we = 1'b1; e.alu = ALU_ADD; e.src_b = 1'b1;
    step("x0_rd", 32'h0000_0393, 32'h108, 32'h10C, e);

    e = mk(32'hFE00_0EE3, 32'h10C, 32'h110);
    e.imm = 32'hFFFF_FFFC; e.br = 1'b1; e.alu = ALU_SUB;
    step("beq", 32'hFE00_0EE3, 32'h10C, 32'h110, e);

    e = mk(32'h1234_5537, 32'h110, 32'h114);
    e.imm = 32'h1234_5000; e.rd = 5'd10; e.reg_we = 1'b1; e.alu = ALU_PASS_B; e.src_b = 1'b1; e.chk_a = 1'b0;
    step("lui", 32'h1234_5537, 32'h110, 32'h114, e);

    e = mk(32'hFFFF_F597, 32'h114, 32'h118);
    e.imm = 32'hFFFF_F000; e.rd = 5'd11; e.reg_we = 1'b1; e.alu = ALU_ADD; e.src_a = 1'b1; e.src_b = 1'b1;
    step("auipc", 32'hFFFF_F597, 32'h114, 32'h118, e);

    e = mk(32'h0050_2423, 32'h118, 32'h11C);
    e.rs2d = 32'h1234_5678; e.imm = 32'd8; e.mem_we = 1'b1; e.alu = ALU_ADD; e.src_b = 1'b1;
    step("sw", 32'h0050_2423, 32'h118, 32'h11C, e);

    e = mk(32'hFFC2_A603, 32'h11C, 32'h120);
    e.rs1d = 32'h1234_5678; e.imm = 32'hFFFF_FFFC; e.rd = 5'd12; e.reg_we = 1'b1;
    e.mem_re = 1'b1; e.wb = WB_MEM; e.alu = ALU_ADD; e.src_b = 1'b1;
    step("lw", 32'hFFC2_A603, 32'h11C, 32'h120, e);

    e = mk(32'h0080_00EF, 32'h120, 32'h124);
    e.imm = 32'd8; e.rd = 5'd1; e.reg_we = 1'b1; e.jal = 1'b1; e.wb = WB_PC4;
    e.alu = ALU_ADD; e.src_a = 1'b1; e.src_b = 1'b1;
    step("jal", 32'h0080_00EF, 32'h120, 32'h124, e);

    e = mk(32'h0000_8067, 32'h124, 32'h128);
    e.rs1d = 32'hDEAD_BEEF; e.reg_we = 1'b1; e.jalr = 1'b1; e.wb = WB_PC4; e.alu = ALU_ADD; e.src_b = 1'b1;
    step("jalr", 32'h0000_8067, 32'h124, 32'h128, e);

    e = mk(32'h4032_D213, 32'h128, 32'h12C);
    e.rs1d = 32'h1234_5678; e.imm = 32'h0000_0403; e.rd = 5'd4; e.reg_we = 1'b1; e.alu = ALU_SRA; e.src_b = 1'b1;
    step("srai", 32'h4032_D213, 32'h128, 32'h12C, e);

    e = mk(32'h4002_8213, 32'h12C, 32'h130);
    e.rs1d = 32'h1234_5678; e.imm = 32'h0000_0400; e.rd = 5'd4; e.reg_we = 1'b1; e.alu = ALU_ADD; e.src_b = 1'b1;
    step("addi_b30", 32'h4002_8213, 32'h12C, 32'h130, e);

    e = mk(32'h4062_81B3, 32'h130, 32'h134);
    e.rs1d = 32'h1234_5678; e.rd = 5'd3; e.reg_we = 1'b1; e.alu = ALU_SUB; e.chk_imm = 1'b0;
    step("sub", 32'h4062_81B3, 32'h130, 32'h134, e);

    e = mk(32'h8000_0033, 32'h134, 32'h138);
    e.ill = 1'b1; e.chk_imm = 1'b0;
    step("bad_f7", 32'h8000_0033, 32'h134, 32'h138, e);

    held = mk(32'h0002_8313, 32'h200, 32'h204);
    held.rs1d = 32'h1234_5678; held.rd = 5'd6; held.reg_we = 1'b1; held.alu = ALU_ADD; held.src_b = 1'b1;
    step("pre_stall", 32'h0002_8313, 32'h200, 32'h204, held);
    stall_id = 1'b1;
    step("stall1", 32'hFFFF_FFFF, 32'h204, 32'h208, held);
    step("stall2", 32'h0000_0393, 32'h208, 32'h20C, held);
    flush_id = 1'b1;
    step("flush", 32'h0002_8313, 32'h20C, 32'h210, mk(32'h0, 32'h0, 32'h0));
    stall_id = 1'b0; flush_id = 1'b0;

    e = mk(32'hFFFF_FFFF, 32'h210, 32'h214);
    e.ill = 1'b1; e.chk_imm = 1'b0;
    step("illegal", 32'hFFFF_FFFF, 32'h210, 32'h214, e);

    // asynchronous reset mid-run clears ID/EX immediately and the register file
    reset = 1'b1;
    #1;
    exp_q.push_back(mk(32'h0, 32'h0, 32'h0));
    compare_out("rst_async");
    @(posedge clk);
    #1;
    reset = 1'b0;
    e = mk(32'h0002_8313, 32'h300, 32'h304);
    e.rd = 5'd6; e.reg_we = 1'b1; e.alu = ALU_ADD; e.src_b = 1'b1;
    step("rf_cleared", 32'h0002_8313, 32'h300, 32'h304, e);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/decode_stage.md
Name: decode_stage

Overview:
RV32I instruction-decode stage that sits directly downstream of the fetch stage and its IF/ID register. It consumes the IF/ID instruction word, PC and PC+4, then decodes the control signals and generates the immediate. It also reads a 32x32 register file, which the writeback stage writes, and registers all results into the ID/EX pipeline register. The hazard unit controls the ID/EX register with stall and flush.

Parameters:
XLEN, 32, datapath width
NREGS, 32, architectural registers; x0 hardwired to zero

Ports:
clk  input  1  clock
reset  input  1  asynchronous, active-high reset
instr_if  input  32  instruction word from the IF/ID register
pc_if  input  32  PC from the IF/ID register
pc4_if  input  32  PC+4 from the IF/ID register
wb_we  input  1  register-file write enable from writeback
wb_rd  input  5  writeback destination register
wb_data  input  32  writeback data
stall_id  input  1  hazard unit: hold the ID/EX register
flush_id  input  1  hazard unit: load a bubble into the ID/EX register
rs1_addr_dec  output  5  combinational instr_if[19:15], to the hazard unit
rs2_addr_dec  output  5  combinational instr_if[24:20], to the hazard unit
rs1_data_id, rs2_data_id  output  32  registered operands
imm_id  output  32  registered sign-extended immediate
rs1_addr_id, rs2_addr_id, rd_addr_id  output  5  registered register addresses
pc_id, pc4_id  output  32  registered PC and PC+4
funct3_id  output  3  registered funct3, used for branch compare and load/store size
alu_ctrl_id  output  4  registered ALU operation (encoding in the package)
alu_src_a_id  output  1  0 = rs1, 1 = PC (AUIPC, JAL)
alu_src_b_id  output  1  0 = rs2, 1 = immediate
wb_sel_id  output  2  0 = ALU result, 1 = memory, 2 = PC+4
reg_we_id, mem_re_id, mem_we_id, branch_id, jal_id, jalr_id  output  1  registered control signals
illegal_id  output  1  unsupported encoding was decoded

Behaviour:
- Reset (asynchronous):
  - every ID/EX output goes to 0;
  - all 31 writable registers clear to 0.
- ID/EX update priority at posedge clk: flush_id > stall_id > load.
  - flush_id: every ID/EX output becomes 0, which is a bubble.
  - stall_id: every ID/EX output holds its value.
  - Otherwise: load the decoded values. Latency is 1 cycle from IF/ID to ID/EX.
- Register file:
  - Written at posedge when wb_we=1 and wb_rd!=0. Writes to x0 are ignored.
  - Reads are combinational. A read of x0 returns 0.
  - Internal bypass: if wb_we=1, wb_rd!=0 and wb_rd equals the read address, the read returns wb_data in the same cycle.
  - Register-file writes proceed during stall_id and during flush_id.
- Opcode decoding: R, I-ALU, LOAD, STORE, BRANCH, JAL, JALR, LUI, AUIPC.
  - LUI: alu_src_a=x, alu_ctrl=PASS_B.
  - AUIPC: alu_ctrl=ADD.
  - JAL/JALR: wb_sel=2.
  - LOAD: wb_sel=1, mem_re=1.
  - STORE and BRANCH: reg_we=0.
- Immediate forms (I, S, B, U, J) are sign-extended from instr[31].
  - B and J immediates have bit 0 = 0.
  - U immediate is {instr[31:12], 12'b0}.
- ALU control:
  - R-type: funct7[5] selects SUB vs ADD and SRA vs SRL.
  - I-type: funct7[5] is honoured only for SRAI. ADDI never decodes as SUB.
  - BRANCH: alu_ctrl=SUB; the compare type comes from funct3_id.
- Bubble and illegal handling:
  - instr_if = 32'h0000_0000 (a bubble from fetch): decode as all-zero controls with illegal_id=0.
  - Any other unsupported opcode, or a bad funct7 on R-type: all write/memory/branch controls are 0 and illegal_id=1.
- rd_addr_id is forced to 0 when reg_we would be 0, so the forwarding logic never matches a non-writing instruction.
- Simultaneous events: flush_id=1 together with stall_id=1 results in a flush.

Decomposition:
- Package riscv_pkg:
  - opcode constants;
  - alu_op_e (ADD, SUB, SLL, SLT, SLTU, XOR, SRL, SRA, OR, AND, PASS_B), 4 bits;
  - wb_sel_e;
  - imm_type_e.
- Sub-module regfile: 2 read ports, 1 write port, with bypass and asynchronous reset.
- Decoder and immediate generator stay inside decode_stage.

Test Plan:
- After reset, apply instr_if=32'h0000_0000 for 3 cycles -> all ID/EX outputs are 0 and illegal_id=0.
- Write x5=32'h1234_5678 via wb. Next, instr_if=32'h0002_8313 (addi x6,x5,0) -> rs1_data_id=32'h1234_5678, imm_id=0, reg_we_id=1, alu_ctrl_id=ADD, rd_addr_id=6.
- Bypass: in the same cycle, wb_we=1, wb_rd=1, wb_data=32'hDEAD_BEEF and instr_if=32'h0000_8033 (add x0,x1,x0) -> rs1_data_id=32'hDEAD_BEEF, rd_addr_id=0, reg_we_id=1.
- Write x0=32'hFFFF_FFFF, then read x0 -> 0.
- instr_if=32'hFE00_0EE3 (beq x0,x0,-4) -> imm_id=32'hFFFF_FFFC, branch_id=1, reg_we_id=0, rd_addr_id=0, alu_ctrl_id=SUB.
- Load addi, then hold stall_id=1 for 2 cycles while instr_if changes -> outputs unchanged.
- Apply flush_id=1 with stall_id=1 -> all outputs are 0 next cycle.
- instr_if=32'hFFFF_FFFF -> illegal_id=1 with all control signals 0.
